ifu_prefetch_q: RTL

//  Parametrised prefetching fetch stage; next generation of the single-IR ifetch.

---
 rtl/ifu_prefetch_q.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/ifu_prefetch_q.sv
// ---------------------------------------------------------------------------
// ifu_prefetch_q
//   Prefetching instruction-fetch stage. Issues sequential word-aligned fetch
//   requests with up to MAX_OUTSTD in flight. Responses come back in request
//   order and are buffered in a DEPTH-entry instruction queue feeding the EXU.
//   A pipeline flush redirects fetch and discards the responses of requests
//   already in flight.
//
//   Optional feature (macro IFU_JAL_PREDICT_EN):
//     JAL instructions are predicted taken as they are pushed. Fetch is
//     redirected to the jump target, the younger in-flight responses are
//     dropped, and the JAL entry is marked prdt_taken. When the macro is not
//     defined, fetch is purely sequential and prdt_taken is always 0.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   pc_rtvec          reset vector, sampled while rst_n is low
//   ifu_req_*         fetch request (valid/ready, word-aligned pc)
//   ifu_rsp_*         fetch response (valid, instr); rsp_ready is tied to 1
//   ifu_o_*           queue head to EXU (valid/ready, ir, pc, prdt_taken)
//   pipe_flush_*      redirect from EXU (req, pc); ack is tied to 1
//   inspect_pc        current fetch PC register
// ---------------------------------------------------------------------------
module ifu_prefetch_q #(
  parameter int PC_SIZE    = 32,
  parameter int INSTR_SIZE = 32,
  parameter int DEPTH      = 4,
  parameter int MAX_OUTSTD = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PC_SIZE-1:0]    pc_rtvec,
  output logic                  ifu_req_valid,
  input  logic                  ifu_req_ready,
  output logic [PC_SIZE-1:0]    ifu_req_pc,
  input  logic                  ifu_rsp_valid,
  output logic                  ifu_rsp_ready,
  input  logic [INSTR_SIZE-1:0] ifu_rsp_instr,
  output logic                  ifu_o_valid,
  input  logic                  ifu_o_ready,
  output logic [INSTR_SIZE-1:0] ifu_o_ir,
  output logic [PC_SIZE-1:0]    ifu_o_pc,
  output logic                  ifu_o_prdt_taken,
  input  logic                  pipe_flush_req,
  input  logic [PC_SIZE-1:0]    pipe_flush_pc,
  output logic                  pipe_flush_ack,
  output logic [PC_SIZE-1:0]    inspect_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTD + 1);
  localparam int SW = CW + 1;

  localparam logic [PC_SIZE-1:0] ALIGN_MASK = {{(PC_SIZE-2){1'b1}}, 2'b00};
  localparam logic [PC_SIZE-1:0] PC_STEP    = PC_SIZE'(4);
  localparam logic [PW-1:0]      PTR_LAST   = PW'(DEPTH - 1);
  localparam logic [PW-1:0]      PTR_ONE    = PW'(1);
  localparam logic [CW-1:0]      CNT_ONE    = CW'(1);
  localparam logic [OW-1:0]      OSD_ONE    = OW'(1);
  localparam logic [OW-1:0]      OSD_MAX    = OW'(MAX_OUTSTD);
  localparam logic [SW-1:0]      CREDIT_MAX = SW'(DEPTH);

  logic [PC_SIZE-1:0]    fpc;
  logic [PC_SIZE-1:0]    rsp_pc;
  logic [OW-1:0]         outstd;
  logic [OW-1:0]         drop_cnt;

  logic [INSTR_SIZE-1:0] q_ir   [DEPTH];
  logic [PC_SIZE-1:0]    q_pc   [DEPTH];
  logic [DEPTH-1:0]      q_prdt;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;

  logic                  req_hs;
  logic                  rsp_hs;
  logic                  rsp_drop;
  logic                  push;
  logic                  pop;
  logic                  rsp_is_jal;
  logic                  redirect;
  logic [PC_SIZE-1:0]    redirect_pc;
  logic [PC_SIZE-1:0]    rsp_pc_next;
  logic [PC_SIZE-1:0]    flush_pc_al;
  logic                  credit_ok;
  logic [PW-1:0]         rd_next;
  logic [CW-1:0]         cnt_next;
  logic                  head_bypass;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  assign ifu_rsp_ready  = 1'b1;
  assign pipe_flush_ack = 1'b1;
  assign ifu_req_pc     = fpc;
  assign inspect_pc     = fpc;
  assign ifu_o_valid    = (count != '0);

  assign rsp_hs      = ifu_rsp_valid;
  assign rsp_drop    = rsp_hs & (drop_cnt != '0);
  assign push        = rsp_hs & ~rsp_drop & ~pipe_flush_req;
  assign pop         = ifu_o_valid & ifu_o_ready & ~pipe_flush_req;
  assign rsp_pc_next = rsp_pc + PC_STEP;
  assign flush_pc_al = pipe_flush_pc & ALIGN_MASK;

`ifdef IFU_JAL_PREDICT_EN
  // A kept response carrying a JAL redirects fetch to rsp_pc + J-immediate.
  // The flush has already been excluded from push, so a flush in the same
  // cycle wins and the JAL never reaches the queue.
  logic [20:0] jal_imm;
  assign rsp_is_jal  = (ifu_rsp_instr[6:0] == 7'b1101111);
  assign jal_imm     = {ifu_rsp_instr[31], ifu_rsp_instr[19:12], ifu_rsp_instr[20],
                        ifu_rsp_instr[30:21], 1'b0};
  assign redirect    = push & rsp_is_jal;
  assign redirect_pc = (rsp_pc + {{(PC_SIZE-21){jal_imm[20]}}, jal_imm}) & ALIGN_MASK;
`else
  // Without prediction the fetch stream is purely sequential.
  assign rsp_is_jal  = 1'b0;
  assign redirect    = 1'b0;
  assign redirect_pc = rsp_pc_next;
`endif

  // A request slot is granted only if a queue entry is guaranteed for its
  // response, counting both buffered and in-flight instructions. This credit
  // scheme is what keeps the queue from ever overflowing.
  assign credit_ok     = (SW'(outstd) + SW'(count)) < CREDIT_MAX;
  assign ifu_req_valid = ~pipe_flush_req & ~redirect & (outstd < OSD_MAX) & credit_ok;
  assign req_hs        = ifu_req_valid & ifu_req_ready;

  // Work out where the head of the queue will be after this cycle. When the
  // queue is (or becomes) empty and an entry is pushed, the new head is the
  // incoming response itself rather than a storage slot.
  always_comb begin
    rd_next     = pop ? ptr_inc(rd_ptr) : rd_ptr;
    cnt_next    = count;
    head_bypass = 1'b0;
    if (push & ~pop) begin
      cnt_next = count + CNT_ONE;
    end else if (~push & pop) begin
      cnt_next = count - CNT_ONE;
    end
    if (push & ((count == '0) | ((count == CNT_ONE) & pop))) begin
      head_bypass = 1'b1;
    end
  end

  // Fetch-side state: fetch PC, PC of the next kept response, in-flight
  // request count and the number of stale responses still to discard.
  // Flush takes priority over a JAL redirect; both stop issue for the cycle,
  // so everything still in flight at that point is stale except a response
  // handshaking in that same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc      <= pc_rtvec & ALIGN_MASK;
      rsp_pc   <= pc_rtvec & ALIGN_MASK;
      outstd   <= '0;
      drop_cnt <= '0;
    end else begin
      if (req_hs & ~rsp_hs) begin
        outstd <= outstd + OSD_ONE;
      end else if (~req_hs & rsp_hs) begin
        outstd <= outstd - OSD_ONE;
      end

      if (pipe_flush_req) begin
        fpc      <= flush_pc_al;
        rsp_pc   <= flush_pc_al;
        drop_cnt <= rsp_hs ? (outstd - OSD_ONE) : outstd;
      end else if (redirect) begin
        fpc      <= redirect_pc;
        rsp_pc   <= redirect_pc;
        drop_cnt <= outstd - OSD_ONE;
      end else begin
        if (req_hs) begin
          fpc <= fpc + PC_STEP;
        end
        if (rsp_drop) begin
          drop_cnt <= drop_cnt - OSD_ONE;
        end else if (rsp_hs) begin
          rsp_pc <= rsp_pc_next;
        end
      end
    end
  end

  // Queue pointers and occupancy. A flush empties the queue outright,
  // discarding any push or pop requested in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (pipe_flush_req) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      rd_ptr <= rd_next;
      count  <= cnt_next;
    end
  end

  // Queue storage. Contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      q_ir[wr_ptr]   <= ifu_rsp_instr;
      q_pc[wr_ptr]   <= rsp_pc;
      q_prdt[wr_ptr] <= rsp_is_jal;
    end
  end

  // Registered head outputs. They are reloaded whenever the queue will hold
  // an entry next cycle and otherwise keep their last value, so an empty
  // queue shows the most recent head with ifu_o_valid low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifu_o_ir         <= '0;
      ifu_o_pc         <= '0;
      ifu_o_prdt_taken <= 1'b0;
    end else if (~pipe_flush_req & (cnt_next != '0)) begin
      if (head_bypass) begin
        ifu_o_ir         <= ifu_rsp_instr;
        ifu_o_pc         <= rsp_pc;
        ifu_o_prdt_taken <= rsp_is_jal;
      end else begin
        ifu_o_ir         <= q_ir[rd_next];
        ifu_o_pc         <= q_pc[rd_next];
        ifu_o_prdt_taken <= q_prdt[rd_next];
      end
    end
  end

endmodule
